mult_operand_packer: RTL

- Upstream feeder for multiplier_interface.
- Takes a byte stream (e.g. UART rx) and pairs consecutive bytes as {multiplicand, multiplier}.
- Writes each pair as one 16-bit word into the multiplier FIFO, and only when left_sig shows free space.
- Discards stale half-pairs on timeout or flush.

---
 rtl/mult_operand_packer_pkg.sv | 17 +
 rtl/mult_pair_timer.sv | 31 +++
 rtl/mult_operand_packer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mult_operand_packer_pkg.sv
// Shared definitions for the multiplier operand path.
// Holds the packer/interface state encodings and the operand, word and free-space widths.
package mult_operand_packer_pkg;

    localparam int OPND_W = 8;
    localparam int WORD_W = 16;
    localparam int LEFT_W = 3;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_CHK = 3'd2,
        S_WR  = 3'd3,
        S_GAP = 3'd4
    } state_t;

endpackage

// File: rtl/mult_pair_timer.sv
// Idle timer for the half-pair wait state.
// Ports: clk, rst_n, clear (restart at 0), enable (count this cycle),
// expire (last allowed cycle reached). TIMEOUT = 0 keeps expire low.
module mult_pair_timer #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/mult_operand_packer.sv
// Pairs consecutive bytes into {multiplicand, multiplier} FIFO words.
// Ports: clk, rst_n, byte_valid/byte_data/byte_ready (byte in), flush,
// left_sig (FIFO space), write_req/fifo_write_data (FIFO write),
// drop_pulse, busy. Optional MULT_PACKER_STAT_EN adds pair_cnt, drop_cnt.
module mult_operand_packer
    import mult_operand_packer_pkg::*;
#(
    parameter int unsigned MIN_SPACE = 1,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [OPND_W-1:0] byte_data,
    output logic              byte_ready,
    input  logic              flush,
    input  logic [LEFT_W-1:0] left_sig,
    output logic              write_req,
    output logic [WORD_W-1:0] fifo_write_data,
    output logic              drop_pulse,
    output logic              busy
`ifdef MULT_PACKER_STAT_EN
    ,
    output logic [15:0]       pair_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   expire;
    logic   drop_nxt;
    logic   tmr_clear;
    logic   tmr_en;

    assign byte_ready = (state == S_A || state == S_B) && !flush;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state != S_A);
    assign tmr_en     = (state == S_B);
    assign tmr_clear  = (state != S_B) || accept || flush;

    mult_pair_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        unique case (state)
            S_A: begin
                if (accept) state_nxt = S_B;
            end
            S_B: begin
                if (flush) begin
                    state_nxt = S_A;
                    drop_nxt  = 1'b1;
                end else if (accept) begin
                    state_nxt = S_CHK;
                end else if (expire) begin
                    state_nxt = S_A;
                    drop_nxt  = 1'b1;
                end
            end
            S_CHK: begin
                if (flush) begin
                    state_nxt = S_A;
                end else if (left_sig >= LEFT_W'(MIN_SPACE)) begin
                    state_nxt = S_WR;
                end
            end
            // A write already issued is committed; flush is ignored here.
            S_WR:    state_nxt = S_GAP;
            S_GAP:   state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_A;
            write_req       <= 1'b0;
            drop_pulse      <= 1'b0;
            fifo_write_data <= '0;
        end else begin
            state      <= state_nxt;
            write_req  <= (state_nxt == S_WR);
            drop_pulse <= drop_nxt;
            if (accept && state == S_A) begin
                fifo_write_data[WORD_W-1:OPND_W] <= byte_data;
            end
            if (accept && state == S_B) begin
                fifo_write_data[OPND_W-1:0] <= byte_data;
            end
        end
    end

`ifdef MULT_PACKER_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (write_req) pair_cnt <= pair_cnt + 16'd1;
            if (drop_pulse && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
